mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory load/store sequencer feeding the register writeback stage.
- Decodes load/store cuOP codes and issues one bus transaction per instruction over a req/ack handshake.
- Holds the core via `freeze` until the transaction completes, then presents a right-justified load word on `memload`.
- Writeback performs the final sign/zero extension.

Parameters:
- ADDR_W, 32, bus address width
- TIMEOUT, 255, max cycles to wait for `bus_ack` before aborting (8-bit counter)

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- cuOP  in  6  decoded operation (cuOPType encoding)
- addr  in  ADDR_W  effective address (ALU result)
- store_data  in  32  rs2 value
- bus_rdata  in  32  read data from bus, valid with `bus_ack`
- bus_ack  in  1  single-cycle transaction-complete strobe
- bus_req  out  1  transaction request, held until `bus_ack`
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_sel  out  4  byte enables
- memload  out  32  loaded data, right-justified
- freeze  out  1  stall PC/fetch while high
- misaligned  out  1  one-cycle pulse on misaligned access
- timeout_err  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (async, nRst low): state IDLE; all outputs 0; memload 0; timeout counter 0.
- Access class:
  - LB/LBU/SB: byte.
  - LH/LHU/SH: half.
  - LW/SW: word.
  - All other cuOP values: no access.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Load/store, aligned: assert `bus_req` and `freeze` combinationally in the same cycle; register the transaction; go to ACCESS.
  - Misaligned: pulse `misaligned`; no bus request; `freeze` stays 0; remain IDLE.
  - Non-memory cuOP: `freeze` 0; outputs idle.
- ACCESS:
  - Hold `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_sel` stable; `freeze` = 1.
  - Count cycles without `bus_ack`.
  - On `bus_ack`:
    - Deassert `bus_req` next cycle.
    - For loads, latch memload = bus_rdata >> (8*addr[1:0]) for byte/half, or bus_rdata for word. Upper bits are don't-care to writeback but must equal the shifted value.
    - Go to DONE.
  - If count reaches TIMEOUT: drop `bus_req`, pulse `timeout_err`, memload = 0, go to DONE.
- DONE:
  - `freeze` = 0 for exactly one cycle so the PC advances; `memload` valid.
  - Return to IDLE.
  - This prevents re-issue on the still-present cuOP.
- Store data and enables:
  - SB: bus_sel = 1<<addr[1:0]; bus_wdata = {4{store_data[7:0]}}.
  - SH: bus_sel = 4'b0011<<addr[1:0]; bus_wdata = {2{store_data[15:0]}}.
  - SW: bus_sel = 4'b1111; bus_wdata = store_data.
  - Loads: bus_sel per access class, same rules as stores.
- memload holds its last value in IDLE.
- cuOP/addr changes during ACCESS are ignored; the registered copy is used.
- `bus_ack` in IDLE/DONE is ignored.
- Async reset mid-ACCESS: immediate return to IDLE with `bus_req`=0. The bus must tolerate an abandoned request.

Decomposition:
- Shared package `cpu_pkg`:
  - cuOPType enum with values 0..38; LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17.
  - Access-class enum {ACC_NONE, ACC_BYTE, ACC_HALF, ACC_WORD}.
- One sub-module: `lsu_align`, combinational. Computes access class, misalignment, bus_sel, bus_wdata and the load shift.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LB, addr=0x1002, bus_rdata=0xAA55CC33, ack after 3 cycles:
  - `freeze` high 4 cycles; bus_addr=0x1000, bus_sel=0100.
  - memload[7:0]=0x55 in DONE; one `freeze`-low DONE cycle, then IDLE.
- SH, addr=0x2002, store_data=0x1234BEEF, ack after 1 cycle:
  - bus_we=1, bus_sel=1100, bus_wdata=0xBEEFBEEF.
  - No memload change.
- LW, addr=0x3001:
  - `misaligned` pulses 1 cycle; `bus_req` never asserts; `freeze` stays 0.
- LW, addr=0x4000, no ack:
  - `bus_req` high TIMEOUT cycles, then `timeout_err` pulse; memload=0; DONE then IDLE.
- cuOP=ADD for 5 cycles:
  - bus_req=0, freeze=0; memload unchanged.
- nRst low for 1 cycle mid-ACCESS of an SW:
  - bus_req, freeze and memload are 0 immediately.
  - After release with SW still present, a fresh request issues.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decoded operation codes, load/store access classes
// and the sequencer state type used by the memory access unit.
package cpu_pkg;

    typedef enum logic [5:0] {
        NOP   = 6'd0,  ADD   = 6'd1,  SUB   = 6'd2,  AND   = 6'd3,
        OR    = 6'd4,  XOR   = 6'd5,  SLL   = 6'd6,  SRL   = 6'd7,
        SRA   = 6'd8,  SLT   = 6'd9,  LB    = 6'd10, LH    = 6'd11,
        LW    = 6'd12, LBU   = 6'd13, LHU   = 6'd14, SB    = 6'd15,
        SH    = 6'd16, SW    = 6'd17, SLTU  = 6'd18, LUI   = 6'd19,
        AUIPC = 6'd20, JAL   = 6'd21, JALR  = 6'd22, BEQ   = 6'd23,
        BNE   = 6'd24, BLT   = 6'd25, BGE   = 6'd26, BLTU  = 6'd27,
        BGEU  = 6'd28, ADDI  = 6'd29, SLTI  = 6'd30, SLTIU = 6'd31,
        XORI  = 6'd32, ORI   = 6'd33, ANDI  = 6'd34, SLLI  = 6'd35,
        SRLI  = 6'd36, SRAI  = 6'd37, HALT  = 6'd38
    } cuOPType;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } lsu_state_e;

    function automatic acc_class_e acc_class(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return ACC_BYTE;
            LH, LHU, SH: return ACC_HALF;
            LW, SW:      return ACC_WORD;
            default:     return ACC_NONE;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_sel;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: access class, misalignment, byte enables,
// lane-replicated store data and right-justified load data.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output acc_class_e  acc,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    assign acc      = acc_class(op);
    assign is_store = is_store_op(op);

    always_comb begin
        misaligned = 1'b0;
        sel        = 4'b0000;
        case (acc)
            ACC_BYTE: sel = 4'b0001 << offset;
            ACC_HALF: begin
                sel        = 4'b0011 << offset;
                misaligned = offset[0];
            end
            ACC_WORD: begin
                sel        = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: ;
        endcase
    end

    // Replicate the store operand across all lanes so bus_sel alone picks the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[8*gi +: 8] = (acc == ACC_BYTE) ? store_data[7:0] :
                                      (acc == ACC_HALF) ? store_data[8*(gi%2) +: 8] :
                                                          store_data[8*gi +: 8];
        end
    endgenerate

    // Word accesses are aligned, so the same shift serves every class.
    assign load_data = rdata >> {offset, 3'b000};
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: issues one bus transaction per memory cuOP, freezes the
// core until it completes and presents the right-justified load word.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [5:0]        cuOP,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    mem_access_unit_if.master bus,
    output logic [31:0]       memload,
    output logic              freeze,
    output logic              misaligned,
    output logic              timeout_err
);
    // The issue cycle counts as the first request cycle, so the last one is TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       memload_q, memload_d;
    logic              tmo_q, tmo_d;

    logic              in_access;
    logic [5:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_sdata;

    acc_class_e        acc;
    logic              is_store;
    logic              mis;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    logic              req_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       wdata_c;
    logic [3:0]        sel_c;
    logic              freeze_c;
    logic              mis_c;

    // While a transaction is open the registered copy drives the lanes, so the
    // core may change cuOP/addr freely without disturbing the bus.
    assign in_access = (state_q == ST_ACCESS);
    assign sel_op    = in_access ? op_q    : cuOP;
    assign sel_addr  = in_access ? addr_q  : addr;
    assign sel_sdata = in_access ? sdata_q : store_data;

    lsu_align u_align (
        .op         (sel_op),
        .offset     (sel_addr[1:0]),
        .store_data (sel_sdata),
        .rdata      (bus.bus_rdata),
        .acc        (acc),
        .is_store   (is_store),
        .misaligned (mis),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            op_q      <= 6'd0;
            addr_q    <= '0;
            sdata_q   <= 32'd0;
            cnt_q     <= 8'd0;
            memload_q <= 32'd0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            cnt_q     <= cnt_d;
            memload_q <= memload_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        cnt_d     = cnt_q;
        memload_d = memload_q;
        tmo_d     = 1'b0;
        req_c     = 1'b0;
        freeze_c  = 1'b0;
        mis_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gating on nRst keeps every output quiet while reset is held.
                if (nRst && (acc != ACC_NONE)) begin
                    if (mis) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c    = 1'b1;
                        freeze_c = 1'b1;
                        op_d     = cuOP;
                        addr_d   = addr;
                        sdata_d  = store_data;
                        cnt_d    = 8'd1;
                        state_d  = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                req_c    = 1'b1;
                freeze_c = 1'b1;
                if (bus.bus_ack) begin
                    if (!is_store) memload_d = load_data;
                    cnt_d   = 8'd0;
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    memload_d = 32'd0;
                    tmo_d     = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = 32'd0;
        sel_c   = 4'b0000;
        if (req_c) begin
            we_c    = is_store;
            addr_c  = {sel_addr[ADDR_W-1:2], 2'b00};
            wdata_c = is_store ? lane_wdata : 32'd0;
            sel_c   = lane_sel;
        end
    end

    assign bus.bus_req   = req_c;
    assign bus.bus_we    = we_c;
    assign bus.bus_addr  = addr_c;
    assign bus.bus_wdata = wdata_c;
    assign bus.bus_sel   = sel_c;

    assign memload     = memload_q;
    assign freeze      = freeze_c;
    assign misaligned  = mis_c;
    assign timeout_err = tmo_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout,
// idle ALU traffic and asynchronous reset in the middle of a transaction.
module tb_mem_access_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic [5:0]  cuOP;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] memload;
    logic        freeze;
    logic        misaligned;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus_if ();

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .cuOP        (cuOP),
        .addr        (addr),
        .store_data  (store_data),
        .bus         (bus_if.master),
        .memload     (memload),
        .freeze      (freeze),
        .misaligned  (misaligned),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cuOP = SW; addr = 32'h0000_0100; store_data = 32'h1111_2222;
        #3;
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", bus_if.bus_req); end
        n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL rst_freeze: got %0b want 0", freeze); end
        n_cmp++; if (memload !== 32'h0) begin n_err++; $display("FAIL rst_memload: got %h want 00000000", memload); end
        n_cmp++; if (misaligned !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got mis=%0b tmo=%0b want 0/0", misaligned, timeout_err); end
        n_cmp++; if (bus_if.bus_sel !== 4'b0 || bus_if.bus_we !== 1'b0) begin n_err++; $display("FAIL rst_bus: got sel=%b we=%0b want 0000/0", bus_if.bus_sel, bus_if.bus_we); end
        cuOP = ADD;
        $display("tb: reset memload=%h req=%0b", memload, bus_if.bus_req);
    endtask

    task automatic test_lb();
        cuOP = LB; addr = 32'h0000_1002;
        #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_err++; $display("FAIL lb_req_issue: got %0b want 1", bus_if.bus_req); end
        n_cmp++; if (bus_if.bus_addr !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr: got %h want 00001000", bus_if.bus_addr); end
        n_cmp++; if (bus_if.bus_sel !== 4'b0100 || bus_if.bus_we !== 1'b0) begin n_err++; $display("FAIL lb_sel_we: got sel=%b we=%0b want 0100/0", bus_if.bus_sel, bus_if.bus_we); end
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hAA55_CC33;
                cuOP = SUB; addr = 32'h0;
                #1;
            end
            n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL lb_freeze_c%0d: got %0b want 1", c, freeze); end
            n_cmp++; if (bus_if.bus_sel !== 4'b0100) begin n_err++; $display("FAIL lb_sel_hold_c%0d: got %b want 0100", c, bus_if.bus_sel); end
            tick();
        end
        bus_if.bus_ack = 1'b0;
        n_cmp++; if (freeze !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL lb_done: got freeze=%0b req=%0b want 0/0", freeze, bus_if.bus_req); end
        n_cmp++; if (memload !== 32'h0000_AA55) begin n_err++; $display("FAIL lb_memload: got %h want 0000aa55", memload); end
        cuOP = ADD;
        tick();
        n_cmp++; if (freeze !== 1'b0 || bus_if.bus_req !== 1'b0 || memload !== 32'h0000_AA55) begin n_err++; $display("FAIL lb_idle: got freeze=%0b req=%0b memload=%h want 0/0/0000aa55", freeze, bus_if.bus_req, memload); end
        $display("tb: LB addr=00001002 memload=%h", memload);
    endtask

    task automatic test_sh();
        cuOP = SH; addr = 32'h0000_2002; store_data = 32'h1234_BEEF;
        #1;
        n_cmp++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_sel !== 4'b1100) begin n_err++; $display("FAIL sh_we_sel: got we=%0b sel=%b want 1/1100", bus_if.bus_we, bus_if.bus_sel); end
        n_cmp++; if (bus_if.bus_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata: got %h want beefbeef", bus_if.bus_wdata); end
        n_cmp++; if (bus_if.bus_addr !== 32'h0000_2000) begin n_err++; $display("FAIL sh_addr: got %h want 00002000", bus_if.bus_addr); end
        tick();
        cuOP = LB; addr = 32'h0000_0001; store_data = 32'h0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_sel !== 4'b1100 || bus_if.bus_wdata !== 32'hBEEF_BEEF || bus_if.bus_addr !== 32'h0000_2000) begin n_err++; $display("FAIL sh_hold: got we=%0b sel=%b wdata=%h addr=%h want 1/1100/beefbeef/00002000", bus_if.bus_we, bus_if.bus_sel, bus_if.bus_wdata, bus_if.bus_addr); end
        tick();
        bus_if.bus_ack = 1'b0;
        n_cmp++; if (memload !== 32'h0000_AA55) begin n_err++; $display("FAIL sh_memload: got %h want 0000aa55", memload); end
        n_cmp++; if (freeze !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL sh_done: got freeze=%0b req=%0b want 0/0", freeze, bus_if.bus_req); end
        cuOP = ADD;
        tick();
        $display("tb: SH addr=00002002 wdata=beefbeef memload=%h", memload);
    endtask

    task automatic test_misaligned();
        cuOP = LW; addr = 32'h0000_3001;
        #1;
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_lw_pulse: got %0b want 1", misaligned); end
        n_cmp++; if (bus_if.bus_req !== 1'b0 || freeze !== 1'b0) begin n_err++; $display("FAIL mis_lw_noreq: got req=%0b freeze=%0b want 0/0", bus_if.bus_req, freeze); end
        tick();
        cuOP = LH; addr = 32'h0000_3003;
        #1;
        n_cmp++; if (misaligned !== 1'b1 || bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL mis_lh: got mis=%0b req=%0b want 1/0", misaligned, bus_if.bus_req); end
        tick();
        cuOP = ADD;
        #1;
        n_cmp++; if (misaligned !== 1'b0 || bus_if.bus_req !== 1'b0 || freeze !== 1'b0) begin n_err++; $display("FAIL mis_after: got mis=%0b req=%0b freeze=%0b want 0/0/0", misaligned, bus_if.bus_req, freeze); end
        $display("tb: LW addr=00003001 misaligned, no request");
    endtask

    task automatic test_timeout();
        int hi = 0;
        cuOP = LW; addr = 32'h0000_4000;
        #1;
        for (int i = 0; i < 300 && bus_if.bus_req === 1'b1; i++) begin
            hi++;
            tick();
        end
        n_cmp++; if (hi != 255) begin n_err++; $display("FAIL tmo_req_cycles: got %0d want 255", hi); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got %0b want 1", timeout_err); end
        n_cmp++; if (memload !== 32'h0 || freeze !== 1'b0) begin n_err++; $display("FAIL tmo_done: got memload=%h freeze=%0b want 00000000/0", memload, freeze); end
        cuOP = ADD;
        tick();
        n_cmp++; if (timeout_err !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL tmo_after: got tmo=%0b req=%0b want 0/0", timeout_err, bus_if.bus_req); end
        $display("tb: LW addr=00004000 timeout after %0d request cycles", hi);
    endtask

    task automatic test_idle_add();
        cuOP = ADD; addr = 32'h0000_1234;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5A5A_5A5A;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus_if.bus_req !== 1'b0 || freeze !== 1'b0) begin n_err++; $display("FAIL add_c%0d: got req=%0b freeze=%0b want 0/0", c, bus_if.bus_req, freeze); end
            n_cmp++; if (memload !== 32'h0) begin n_err++; $display("FAIL add_mem_c%0d: got %h want 00000000", c, memload); end
            tick();
        end
        bus_if.bus_ack = 1'b0;
        $display("tb: ADD x5 idle memload=%h", memload);
    endtask

    task automatic test_reset_mid();
        cuOP = LW; addr = 32'h0000_5004;
        tick();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_if.bus_ack = 1'b0;
        n_cmp++; if (memload !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_memload: got %h want deadbeef", memload); end
        cuOP = ADD;
        tick();
        cuOP = SW; addr = 32'h0000_6000; store_data = 32'hCAFE_F00D;
        tick();
        #2;
        nRst = 1'b0;
        #1;
        n_cmp++; if (bus_if.bus_req !== 1'b0 || freeze !== 1'b0 || memload !== 32'h0) begin n_err++; $display("FAIL rstmid: got req=%0b freeze=%0b memload=%h want 0/0/00000000", bus_if.bus_req, freeze, memload); end
        @(posedge clk);
        #2;
        nRst = 1'b1;
        #1;
        n_cmp++; if (bus_if.bus_req !== 1'b1 || freeze !== 1'b1) begin n_err++; $display("FAIL rstmid_reissue: got req=%0b freeze=%0b want 1/1", bus_if.bus_req, freeze); end
        n_cmp++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_sel !== 4'b1111 || bus_if.bus_wdata !== 32'hCAFE_F00D || bus_if.bus_addr !== 32'h0000_6000) begin n_err++; $display("FAIL rstmid_bus: got we=%0b sel=%b wdata=%h addr=%h want 1/1111/cafef00d/00006000", bus_if.bus_we, bus_if.bus_sel, bus_if.bus_wdata, bus_if.bus_addr); end
        tick();
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        n_cmp++; if (freeze !== 1'b0 || memload !== 32'h0) begin n_err++; $display("FAIL rstmid_done: got freeze=%0b memload=%h want 0/00000000", freeze, memload); end
        cuOP = ADD;
        tick();
        $display("tb: SW addr=00006000 reset mid-access then reissued");
    endtask

    initial begin
        nRst = 1'b0; cuOP = ADD; addr = 32'h0; store_data = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        test_reset();
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        tick();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_idle_add();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
